// File: rtl/video_timing_pkg.sv
// Shared constants for the raster timing generator: default 640x480@60 mode
// and the helper that sums porch/sync/active spans into a line or frame total.
package video_timing_pkg;

  localparam int   H_ACTIVE_640 = 640;
  localparam int   H_FP_640     = 16;
  localparam int   H_SYNC_640   = 96;
  localparam int   H_BP_640     = 48;
  localparam int   V_ACTIVE_640 = 480;
  localparam int   V_FP_640     = 10;
  localparam int   V_SYNC_640   = 2;
  localparam int   V_BP_640     = 33;
  localparam logic HS_POL_640   = 1'b0;
  localparam logic VS_POL_640   = 1'b0;
  localparam int   CW_640       = 12;

  function automatic int total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N up counter with synchronous clear and advance enable; wrap flags the
// terminal count so a cascaded counter can advance on the same edge.
module mod_counter #(
  parameter int CW      = 12,
  parameter int MODULUS = 800
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST = CW'(MODULUS - 1);

  assign wrap = (count == LAST);

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: cascaded h/v counters, region decode and a single
// aligned output register stage. Held clear while the clock stage is unlocked.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_640,
  parameter int   H_FP     = H_FP_640,
  parameter int   H_SYNC   = H_SYNC_640,
  parameter int   H_BP     = H_BP_640,
  parameter int   V_ACTIVE = V_ACTIVE_640,
  parameter int   V_FP     = V_FP_640,
  parameter int   V_SYNC   = V_SYNC_640,
  parameter int   V_BP     = V_BP_640,
  parameter logic HS_POL   = HS_POL_640,
  parameter logic VS_POL   = VS_POL_640,
  parameter int   CW       = CW_640
) (
  input  logic          clkin,
  input  logic          reset,
  input  logic          locked,
  input  logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
      CW <= 0 || CW > 30 || H_TOTAL >= (1 << CW) || V_TOTAL >= (1 << CW)) begin : g_bad_params
    $error("video_timing_gen: zero timing parameter or total does not fit in CW bits");
  end

  localparam logic [CW-1:0] H_ACT_C = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_ACT_C = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic          clr;
  logic [CW-1:0] hcount, vcount;
  logic          h_wrap, v_wrap_unused;
  logic          vis, hs_on, vs_on;

  // Loss of lock is treated exactly like reset so a relock always starts a fresh frame.
  assign clr = reset | ~locked;

  mod_counter #(.CW(CW), .MODULUS(H_TOTAL)) u_hcount (
    .clk   (clkin),
    .clr   (clr),
    .en    (pix_en),
    .count (hcount),
    .wrap  (h_wrap)
  );

  mod_counter #(.CW(CW), .MODULUS(V_TOTAL)) u_vcount (
    .clk   (clkin),
    .clr   (clr),
    .en    (pix_en & h_wrap),
    .count (vcount),
    .wrap  (v_wrap_unused)
  );

  assign vis   = (hcount < H_ACT_C) && (vcount < V_ACT_C);
  assign hs_on = (hcount >= HS_BEG) && (hcount < HS_END);
  assign vs_on = (vcount >= VS_BEG) && (vcount < VS_END);

  // Outputs register the decode of the pre-advance counter value, so they trail
  // the counters by one enabled edge and stay mutually aligned.
  always_ff @(posedge clkin) begin
    if (clr) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      active      <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      hsync       <= hs_on ? HS_POL : ~HS_POL;
      vsync       <= vs_on ? VS_POL : ~VS_POL;
      active      <= vis;
      x           <= vis ? hcount : '0;
      y           <= vis ? vcount : '0;
      line_start  <= (hcount == '0);
      frame_start <= (hcount == '0) && (vcount == '0);
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench: a small-mode instance (table vectors, random stimulus vs
// a pixel-index model, wrap/reset corner) and a default 640x480 instance.
module tb_video_timing_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        act;
    logic [11:0] x;
    logic [11:0] y;
    logic        ls;
    logic        fs;
  } out_t;

  typedef struct {
    logic rst;
    logic lck;
    logic en;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Small mode: H 4/1/2/1 (total 8), V 3/1/1/1 (total 6), active-high syncs.
  logic        s_reset, s_locked, s_pix_en;
  logic        s_hsync, s_vsync, s_active, s_line_start, s_frame_start;
  logic [11:0] s_x, s_y;
  out_t        s_out;
  assign s_out = {s_hsync, s_vsync, s_active, s_x, s_y, s_line_start, s_frame_start};

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(12)
  ) u_small (
    .clkin(clk), .reset(s_reset), .locked(s_locked), .pix_en(s_pix_en),
    .hsync(s_hsync), .vsync(s_vsync), .active(s_active), .x(s_x), .y(s_y),
    .line_start(s_line_start), .frame_start(s_frame_start)
  );

  logic        d_reset, d_locked, d_pix_en;
  logic        d_hsync, d_vsync, d_active, d_line_start, d_frame_start;
  logic [11:0] d_x, d_y;
  out_t        d_out;
  assign d_out = {d_hsync, d_vsync, d_active, d_x, d_y, d_line_start, d_frame_start};

  video_timing_gen u_def (
    .clkin(clk), .reset(d_reset), .locked(d_locked), .pix_en(d_pix_en),
    .hsync(d_hsync), .vsync(d_vsync), .active(d_active), .x(d_x), .y(d_y),
    .line_start(d_line_start), .frame_start(d_frame_start)
  );

  function automatic out_t mk(input logic hs, input logic vs, input logic act,
                              input int xv, input int yv, input logic ls, input logic fs);
    out_t o;
    o.hs = hs; o.vs = vs; o.act = act; o.x = 12'(xv); o.y = 12'(yv); o.ls = ls; o.fs = fs;
    return o;
  endfunction

  // Reference: outputs for linear pixel index pos within a frame.
  function automatic out_t model_px(input int pos, input int ha, input int hf, input int hsw,
                                    input int hb, input int va, input int vf, input int vsw,
                                    input int vb, input logic hp, input logic vp);
    int ht, h, v;
    logic vis;
    ht  = ha + hf + hsw + hb;
    h   = pos % ht;
    v   = pos / ht;
    vis = (h < ha) && (v < va);
    return mk((h >= ha + hf && h < ha + hf + hsw) ? hp : ~hp,
              (v >= va + vf && v < va + vf + vsw) ? vp : ~vp,
              vis, vis ? h : 0, vis ? v : 0, h == 0, pos == 0);
  endfunction

  function automatic out_t small_px(input int pos);
    return model_px(pos, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
  endfunction

  function automatic out_t def_px(input int pos);
    return model_px(pos, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[15];
  out_t S_RST, D_RST;

  initial begin
    int   pos, mism, act_cnt, hs_first, hs_len, ls_next;
    logic r_rst, r_lck, r_en;
    out_t exp;

    S_RST = mk(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    D_RST = mk(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    s_reset = 1'b1; s_locked = 1'b0; s_pix_en = 1'b0;
    d_reset = 1'b1; d_locked = 1'b0; d_pix_en = 1'b0;
    tick();

    // ---------------- table-driven small-mode sequence ----------------
    vecs[0]  = '{1'b1, 1'b1, 1'b1, S_RST};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, mk(0, 0, 1, 0, 0, 1, 1)};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, mk(0, 0, 1, 0, 0, 1, 1)};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, mk(0, 0, 1, 1, 0, 0, 0)};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, mk(0, 0, 1, 1, 0, 0, 0)};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, mk(0, 0, 1, 2, 0, 0, 0)};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, mk(0, 0, 1, 3, 0, 0, 0)};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0, 0)};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, mk(1, 0, 0, 0, 0, 0, 0)};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, mk(1, 0, 0, 0, 0, 0, 0)};
    vecs[10] = '{1'b0, 1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0, 0)};
    vecs[11] = '{1'b0, 1'b1, 1'b1, mk(0, 0, 1, 0, 1, 1, 0)};
    vecs[12] = '{1'b0, 1'b0, 1'b1, S_RST};
    vecs[13] = '{1'b0, 1'b1, 1'b0, S_RST};
    vecs[14] = '{1'b0, 1'b1, 1'b1, mk(0, 0, 1, 0, 0, 1, 1)};
    for (int i = 0; i < 15; i++) begin
      s_reset = vecs[i].rst; s_locked = vecs[i].lck; s_pix_en = vecs[i].en;
      tick();
      check($sformatf("vec%0d", i), 64'(s_out), 64'(vecs[i].exp));
    end

    // ---------------- randomized small mode vs model ----------------
    s_reset = 1'b1; s_locked = 1'b1; s_pix_en = 1'b1;
    tick();
    pos = 0;
    exp = S_RST;
    for (int c = 0; c < 3000; c++) begin
      int r;
      r     = int'($urandom_range(0, 199));
      r_rst = (r == 0);
      r_lck = !(r >= 1 && r <= 4);
      r_en  = ($urandom_range(0, 3) != 0);
      s_reset = r_rst; s_locked = r_lck; s_pix_en = r_en;
      tick();
      if (r_rst || !r_lck) begin
        pos = 0;
        exp = S_RST;
      end else if (r_en) begin
        exp = small_px(pos);
        pos = (pos + 1) % 48;
      end
      check($sformatf("rand%0d", c), 64'(s_out), 64'(exp));
    end

    // ---------------- reset on the frame wrap edge ----------------
    s_reset = 1'b1; s_locked = 1'b1; s_pix_en = 1'b1;
    tick();
    s_reset = 1'b0;
    repeat (47) tick();
    check("wrap_pre", 64'(s_out), 64'(mk(1, 0, 0, 0, 0, 0, 0)));
    s_reset = 1'b1;
    tick();
    check("wrap_reset", 64'(s_out), 64'(S_RST));
    s_reset = 1'b0;
    tick();
    check("wrap_restart", 64'(s_out), 64'(mk(0, 0, 1, 0, 0, 1, 1)));

    // ---------------- default 640x480 mode ----------------
    s_reset = 1'b1;
    d_reset = 1'b1; d_locked = 1'b1; d_pix_en = 1'b1;
    tick();
    check("def_reset", 64'(d_out), 64'(D_RST));
    d_reset = 1'b0;
    tick();
    check("def_first", 64'(d_out), 64'(mk(1, 1, 1, 0, 0, 1, 1)));
    mism = 0; act_cnt = 1; hs_first = -1; hs_len = 0; ls_next = -1;
    for (int c = 1; c < 2400; c++) begin
      tick();
      if (d_out !== def_px(c)) begin
        if (mism < 4) $display("FAIL def_model c=%0d: got %h expected %h", c, d_out, def_px(c));
        mism++;
      end
      if (c < 800) begin
        if (d_active) act_cnt++;
        if (!d_hsync) begin
          hs_len++;
          if (hs_first < 0) hs_first = c;
        end
        if (d_line_start) ls_next = -2;
      end else if (c == 800 && d_line_start) begin
        if (ls_next == -1) ls_next = c;
      end
    end
    check("def_model_mismatches", 64'(mism), 64'd0);
    check("def_active_len", 64'(act_cnt), 64'd640);
    check("def_hsync_start", 64'(hs_first), 64'd656);
    check("def_hsync_len", 64'(hs_len), 64'd96);
    check("def_line_period", 64'(ls_next), 64'd800);

    // ---------------- lock drop mid-frame at (300, 1) ----------------
    d_reset = 1'b1;
    tick();
    d_reset = 1'b0;
    repeat (1101) tick();
    check("lock_pre", 64'(d_out), 64'(mk(1, 1, 1, 300, 1, 0, 0)));
    d_locked = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("lock_low%0d", i), 64'(d_out), 64'(D_RST));
    end
    d_locked = 1'b1;
    tick();
    check("lock_restart", 64'(d_out), 64'(mk(1, 1, 1, 0, 0, 1, 1)));
    tick();
    check("lock_next", 64'(d_out), 64'(mk(1, 1, 1, 1, 0, 0, 0)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
